axi_slave_mem: RTL and testbench

- AXI4 memory-mapped slave that sits directly downstream of the team's AXI master and terminates its write and read transactions.
- Contains a word-addressed on-chip RAM.
- Implements independent write (AW/W/B) and read (AR/R) state machines with FIXED, INCR and WRAP burst addressing.
- Serves as the bench target for the master and as a scratch memory in the system.

---
 rtl/axi_slave_mem.sv | 262 ++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// AXI4 memory-mapped slave with a word-addressed on-chip RAM.
// The write path (AW/W/B) and the read path (AR/R) are independent and can run at the same time.
// Burst addressing supports FIXED, INCR and WRAP.
// Optional feature: when AXI_SLV_ERR_EN is defined, every beat outside the RAM window is an error.
//   - An error write beat is dropped and the burst returns SLVERR.
//   - An error read beat returns zero data with SLVERR.
// When the macro is undefined, addresses wrap modulo MEM_DEPTH and every response is OKAY.
//
// Handshake rule for every channel: a beat transfers on the rising edge of m_aclk
// where valid && ready. A source never drops valid or changes its payload
// while valid && !ready.
module axi_slave_mem #(
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        m_aclk,
  input  logic        m_aresetn,
  input  logic [3:0]  s_axi_awid,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [3:0]  s_axi_bid,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_arid,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [3:0]  s_axi_rid,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [31:0] mem [MEM_DEPTH];

  // Word index of a byte address; the truncation wraps at the top of memory.
  function automatic idx_t word_idx(input logic [31:0] addr);
    return idx_t'((addr - ADDR_BASE) >> 2);
  endfunction

`ifdef AXI_SLV_ERR_EN
  // The address is out of range when its offset lies at or beyond the RAM window.
  function automatic logic out_of_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    return (off >> (IDX_W + 2)) != 32'd0;
  endfunction
`endif

  // Address of the beat that follows addr within a burst.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [2:0]  sz;
    logic [31:0] incr;
    logic [31:0] cont;
    logic [31:0] base;
    logic [31:0] nxt;
    logic        wrap_ok;
    sz      = (size > 3'd2) ? 3'd2 : size;
    incr    = 32'd1 << sz;
    cont    = ({24'd0, len} + 32'd1) << sz;
    base    = addr & ~(cont - 32'd1);
    nxt     = addr + incr;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    case (burst)
      2'b00:   return addr;
      2'b10:   return (wrap_ok && (nxt == base + cont)) ? base : nxt;
      default: return nxt;
    endcase
  endfunction

  // ---------------- write path ----------------
  w_state_t    w_state, w_next;
  logic [3:0]  w_id;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic [7:0]  w_beat;
  logic        w_err;
  logic        w_beat_err;
  logic        w_fire;

`ifdef AXI_SLV_ERR_EN
  assign w_beat_err = out_of_range(w_addr);
`else
  assign w_beat_err = 1'b0;
`endif

  assign w_fire      = s_axi_wvalid && s_axi_wready;
  assign s_axi_bid   = w_id;
  assign s_axi_bresp = {w_err, 1'b0};

  // Write state register.
  always_ff @(posedge m_aclk or negedge m_aresetn) begin
    if (!m_aresetn) w_state <= W_IDLE;
    else            w_state <= w_next;
  end

  // Write next-state and channel handshake outputs.
  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && s_axi_wlast) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write burst context: the latched AW fields, the running address and the sticky error flag.
  always_ff @(posedge m_aclk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else if (s_axi_awvalid && s_axi_awready) begin
      w_id    <= s_axi_awid;
      w_addr  <= s_axi_awaddr;
      w_len   <= s_axi_awlen;
      w_size  <= s_axi_awsize;
      w_burst <= s_axi_awburst;
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else if (w_fire) begin
      w_addr  <= next_addr(w_addr, w_len, w_size, w_burst);
      w_beat  <= w_beat + 8'd1;
      w_err   <= w_err | w_beat_err;
    end
  end

  // RAM byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge m_aclk) begin
    if (w_fire && !w_beat_err) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t    r_state, r_next;
  logic [3:0]  r_id;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [7:0]  r_beat;
  logic        r_last_q;
  logic        r_load;
  logic        r_adv;
  logic [31:0] rd_addr;
  logic        rd_err;

  // r_load: an AR handshake happens. r_adv: a beat that is not the last one is accepted.
  assign r_load    = s_axi_arvalid && s_axi_arready;
  assign r_adv     = s_axi_rvalid && s_axi_rready && !r_last_q;
  // rd_addr: the address whose data the R register loads next.
  assign rd_addr   = r_load ? s_axi_araddr : next_addr(r_addr, r_len, r_size, r_burst);
  assign s_axi_rid = r_id;

`ifdef AXI_SLV_ERR_EN
  assign rd_err = out_of_range(rd_addr);
`else
  assign rd_err = 1'b0;
`endif

  // Read state register.
  always_ff @(posedge m_aclk or negedge m_aresetn) begin
    if (!m_aresetn) r_state <= R_IDLE;
    else            r_state <= r_next;
  end

  // Read next-state and channel handshake outputs.
  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = r_last_q;
        if (s_axi_rready && r_last_q) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Registered R beat: data, response and last flag.
  // The register loads on AR or on an accepted non-last beat, so a stalled beat holds steady.
  always_ff @(posedge m_aclk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_beat      <= '0;
      r_last_q    <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= '0;
    end else if (r_load || r_adv) begin
      if (r_load) begin
        r_id     <= s_axi_arid;
        r_len    <= s_axi_arlen;
        r_size   <= s_axi_arsize;
        r_burst  <= s_axi_arburst;
        r_beat   <= '0;
        r_last_q <= (s_axi_arlen == 8'd0);
      end else begin
        r_beat   <= r_beat + 8'd1;
        r_last_q <= (r_beat + 8'd1 == r_len);
      end
      r_addr      <= rd_addr;
      s_axi_rdata <= rd_err ? 32'd0 : mem[word_idx(rd_addr)];
      s_axi_rresp <= rd_err ? 2'b10 : 2'b00;
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomised self-checking bench for axi_slave_mem against a word-array reference model.
// Define AXI_SLV_ERR_EN to build both the model and the DUT with the range-error feature.
module tb_axi_slave_mem;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        m_aclk, m_aresetn;
  logic [3:0]  awid;   logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize; logic [1:0] awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;  logic [3:0] wstrb; logic wlast, wvalid, wready;
  logic [3:0]  bid;    logic [1:0] bresp; logic bvalid, bready;
  logic [3:0]  arid;   logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;    logic [31:0] rdata; logic [1:0] rresp; logic rlast, rvalid, rready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] w_data_buf [16];
  logic [3:0]  w_strb_buf [16];

  axi_slave_mem #(.MEM_DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
    .m_aclk(m_aclk), .m_aresetn(m_aresetn),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  // Clock.
  initial m_aclk = 1'b0;
  always #5 m_aclk = ~m_aclk;

  // ---------------- reference model ----------------
  // Byte address of beat i, computed directly from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input int i);
    int unsigned incr, cont;
    logic [31:0] base;
    incr = 1 << ((size > 2) ? 2 : size);
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      cont = (len + 1) * incr;
      base = start - (start % cont);
      return base + ((start - base + i * incr) % cont);
    end
    return start + i * incr;
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return ((addr - BASE) >> 2) % DEPTH;
  endfunction

  function automatic bit out_rng(input logic [31:0] addr);
`ifdef AXI_SLV_ERR_EN
    return (addr - BASE) >= 4 * DEPTH;
`else
    return (addr == 32'hFFFF_FFFF) && (addr != 32'hFFFF_FFFF);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Write burst from w_data_buf/w_strb_buf, holding bready low for bdelay cycles.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int bdelay);
    int t;
    logic exp_err;
    logic [31:0] a;
    @(negedge m_aclk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (awready !== 1'b1 && t < 50) begin @(negedge m_aclk); t++; end
    n_checks++; if (awready !== 1'b1) $display("FAIL aw_ready: got %b exp 1", awready); else n_pass++;
    @(posedge m_aclk); @(negedge m_aclk);
    awvalid = 1'b0;
    exp_err = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = w_data_buf[i]; wstrb = w_strb_buf[i]; wlast = (i == len); wvalid = 1'b1;
      t = 0;
      while (wready !== 1'b1 && t < 50) begin @(negedge m_aclk); t++; end
      n_checks++; if (wready !== 1'b1) $display("FAIL w_ready beat %0d: got %b exp 1", i, wready); else n_pass++;
      a = beat_addr(addr, len, size, burst, i);
      if (out_rng(a)) exp_err = 1'b1;
      else for (int b = 0; b < 4; b++)
        if (w_strb_buf[i][b]) model_mem[widx(a)][8*b +: 8] = w_data_buf[i][8*b +: 8];
      @(posedge m_aclk); @(negedge m_aclk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    t = 0;
    while (bvalid !== 1'b1 && t < 50) begin @(negedge m_aclk); t++; end
    n_checks++; if (bvalid !== 1'b1) $display("FAIL b_valid: got %b exp 1", bvalid); else n_pass++;
    for (int k = 0; k < bdelay; k++) begin
      n_checks++;
      if ({bvalid, awready} !== 2'b10) $display("FAIL b_hold: bvalid,awready got %b exp 10", {bvalid, awready});
      else n_pass++;
      @(negedge m_aclk);
    end
    n_checks++; if (bid !== id) $display("FAIL b_id: got %h exp %h", bid, id); else n_pass++;
    n_checks++;
    if (bresp !== (exp_err ? 2'b10 : 2'b00)) $display("FAIL b_resp: got %b exp %b", bresp, exp_err ? 2'b10 : 2'b00);
    else n_pass++;
    bready = 1'b1;
    @(posedge m_aclk); @(negedge m_aclk);
    bready = 1'b0;
    n_checks++;
    if ({bvalid, awready} !== 2'b01) $display("FAIL b_done: bvalid,awready got %b exp 01", {bvalid, awready});
    else n_pass++;
  endtask

  // Read burst; mode 0 rready always 1, mode 1 pattern 1,0,0,1, mode 2 random.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int mode);
    logic [31:0] exp_q [$];
    logic [1:0]  resp_q [$];
    logic [31:0] a, exp_d;
    logic [33:0] held;
    int t, i, k;
    bit rr;
    for (int j = 0; j <= len; j++) begin
      a = beat_addr(addr, len, size, burst, j);
      exp_q.push_back(out_rng(a) ? 32'd0 : model_mem[widx(a)]);
      resp_q.push_back(out_rng(a) ? 2'b10 : 2'b00);
    end
    @(negedge m_aclk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (arready !== 1'b1 && t < 50) begin @(negedge m_aclk); t++; end
    n_checks++; if (arready !== 1'b1) $display("FAIL ar_ready: got %b exp 1", arready); else n_pass++;
    @(posedge m_aclk); @(negedge m_aclk);
    arvalid = 1'b0;
    n_checks++; if (rvalid !== 1'b1) $display("FAIL r_latency: rvalid got %b exp 1", rvalid); else n_pass++;
    i = 0; k = 0; t = 0;
    while (i <= len && t < 500) begin
      t++;
      if (rvalid !== 1'b1) begin @(negedge m_aclk); continue; end
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (k % 4 == 0) || (k % 4 == 3);
        default: rr = $urandom_range(0, 1) != 0;
      endcase
      k++;
      if (!rr) begin
        rready = 1'b0;
        held = {rvalid, rlast, rdata};
        @(negedge m_aclk);
        n_checks++;
        if ({rvalid, rlast, rdata} !== held) $display("FAIL r_stable: got %h exp %h", {rvalid, rlast, rdata}, held);
        else n_pass++;
      end else begin
        exp_d = exp_q.pop_front();
        n_checks++; if (rdata !== exp_d) $display("FAIL r_data beat %0d: got %h exp %h", i, rdata, exp_d); else n_pass++;
        n_checks++; if (rlast !== (i == len)) $display("FAIL r_last beat %0d: got %b exp %b", i, rlast, i == len); else n_pass++;
        n_checks++; if (rid !== id) $display("FAIL r_id: got %h exp %h", rid, id); else n_pass++;
        n_checks++;
        if (rresp !== resp_q[0]) $display("FAIL r_resp beat %0d: got %b exp %b", i, rresp, resp_q[0]);
        else n_pass++;
        void'(resp_q.pop_front());
        rready = 1'b1;
        @(posedge m_aclk); @(negedge m_aclk);
        rready = 1'b0;
        i++;
        n_checks++;
        if (i <= len) begin
          if (rvalid !== 1'b1) $display("FAIL r_no_bubble: rvalid got %b exp 1", rvalid); else n_pass++;
        end else begin
          if ({rvalid, arready} !== 2'b01) $display("FAIL r_end: rvalid,arready got %b exp 01", {rvalid, arready});
          else n_pass++;
        end
      end
    end
    n_checks++; if (i != len + 1) $display("FAIL r_timeout: beats got %0d exp %0d", i, len + 1); else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    m_aresetn = 1'b0;
    #12;
    n_checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000)
      $display("FAIL reset_ctrl: got %b exp 110000", {awready, arready, wready, bvalid, rvalid, rlast});
    else n_pass++;
    n_checks++;
    if ({bid, rid, bresp, rresp, rdata} !== 44'd0)
      $display("FAIL reset_data: got %h exp 0", {bid, rid, bresp, rresp, rdata});
    else n_pass++;
    @(negedge m_aclk); m_aresetn = 1'b1;
  endtask

  task automatic test_fill;
    for (int blk = 0; blk < DEPTH / 16; blk++) begin
      for (int i = 0; i < 16; i++) begin w_data_buf[i] = $urandom; w_strb_buf[i] = 4'hF; end
      do_write(4'(blk), BASE + 32'(blk * 64), 8'd15, 3'd2, 2'b01, 0);
    end
  endtask

  task automatic test_single;
    w_data_buf[0] = 32'hDEAD_BEEF; w_strb_buf[0] = 4'hF;
    do_write(4'h5, 32'h10, 8'd0, 3'd2, 2'b01, 0);
    do_read(4'h6, 32'h10, 8'd0, 3'd2, 2'b01, 0);
  endtask

  task automatic test_incr;
    for (int i = 0; i < 4; i++) begin w_data_buf[i] = 32'(i + 1); w_strb_buf[i] = 4'hF; end
    do_write(4'h1, 32'h20, 8'd3, 3'd2, 2'b01, 0);
    do_read(4'h2, 32'h20, 8'd3, 3'd2, 2'b01, 0);
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 4; i++) begin w_data_buf[i] = 32'hA + 32'(i); w_strb_buf[i] = 4'hF; end
    do_write(4'h3, 32'h08, 8'd3, 3'd2, 2'b10, 0);
    do_read(4'h4, 32'h00, 8'd3, 3'd2, 2'b01, 0);
  endtask

  task automatic test_fixed;
    for (int i = 0; i < 4; i++) begin w_data_buf[i] = 32'(i + 5); w_strb_buf[i] = 4'hF; end
    do_write(4'h7, 32'h40, 8'd3, 3'd2, 2'b00, 0);
    do_read(4'h8, 32'h40, 8'd0, 3'd2, 2'b01, 0);
    w_data_buf[0] = 32'h1234_5678; w_strb_buf[0] = 4'hF;
    do_write(4'h9, 32'h44, 8'd0, 3'd2, 2'b01, 0);
    w_data_buf[0] = 32'hFFFF_FFFF; w_strb_buf[0] = 4'b0011;
    do_write(4'h9, 32'h44, 8'd0, 3'd2, 2'b01, 0);
    do_read(4'hA, 32'h44, 8'd0, 3'd2, 2'b01, 0);
  endtask

  task automatic test_backpressure;
    do_read(4'hB, 32'h20, 8'd3, 3'd2, 2'b01, 1);
    for (int i = 0; i < 2; i++) begin w_data_buf[i] = $urandom; w_strb_buf[i] = 4'hF; end
    do_write(4'hC, 32'h60, 8'd1, 3'd2, 2'b01, 5);
  endtask

  task automatic test_random;
    logic [2:0]  sz;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] addr;
    for (int n = 0; n < 20; n++) begin
      sz    = 3'($urandom_range(0, 3));
      len   = 8'($urandom_range(0, 15));
      burst = 2'($urandom_range(0, 2));
      addr  = BASE + (32'($urandom_range(0, 32'h7FF)) & ~((32'd1 << ((sz > 2) ? 2 : sz)) - 1));
      for (int i = 0; i < 16; i++) begin w_data_buf[i] = $urandom; w_strb_buf[i] = 4'($urandom); end
      do_write(4'($urandom), addr, len, sz, burst, $urandom_range(0, 2));
      do_read(4'($urandom), addr, len, sz, burst, 2);
    end
  endtask

  task automatic test_concurrent;
    for (int i = 0; i < 4; i++) begin w_data_buf[i] = $urandom; w_strb_buf[i] = 4'hF; end
    fork
      do_write(4'hD, 32'h100, 8'd3, 3'd2, 2'b01, 1);
      do_read(4'hE, 32'h200, 8'd3, 3'd2, 2'b01, 2);
    join
  endtask

`ifdef AXI_SLV_ERR_EN
  task automatic test_error;
    w_data_buf[0] = 32'hCAFE_F00D; w_strb_buf[0] = 4'hF;
    do_write(4'h2, 32'h400, 8'd0, 3'd2, 2'b01, 0);
    do_read(4'h3, 32'h000, 8'd0, 3'd2, 2'b01, 0);
    do_read(4'h4, 32'h3FC, 8'd1, 3'd2, 2'b01, 0);
  endtask
`endif

  task automatic test_reset_mid_burst;
    @(negedge m_aclk);
    awid = 4'h1; awaddr = 32'h80; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'h2; araddr = 32'h90; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    @(posedge m_aclk); @(negedge m_aclk);
    awvalid = 1'b0; arvalid = 1'b0;
    wdata = 32'h5A5A_0001; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    model_mem[widx(32'h80)] = 32'h5A5A_0001;
    @(posedge m_aclk); @(negedge m_aclk);
    wdata = 32'h5A5A_0002;
    #2 m_aresetn = 1'b0;
    #1;
    n_checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000)
      $display("FAIL mid_reset: got %b exp 110000", {awready, arready, wready, bvalid, rvalid, rlast});
    else n_pass++;
    wvalid = 1'b0;
    @(negedge m_aclk); m_aresetn = 1'b1;
    repeat (2) @(negedge m_aclk);
    n_checks++;
    if ({awready, arready, bvalid, rvalid} !== 4'b1100)
      $display("FAIL post_reset_idle: got %b exp 1100", {awready, arready, bvalid, rvalid});
    else n_pass++;
    do_read(4'h5, 32'h80, 8'd1, 3'd2, 2'b01, 0);
  endtask

  // Sequencer and final report.
  initial begin
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    test_reset;
    test_fill;
    test_single;
    test_incr;
    test_wrap;
    test_fixed;
    test_backpressure;
    test_concurrent;
    test_random;
`ifdef AXI_SLV_ERR_EN
    test_error;
`endif
    test_reset_mid_burst;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog against a hung handshake.
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
